// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch control unit.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_EDIT = 2'd2
    } state_t;

    localparam int NUM_DIGITS = 4;
    localparam int DIGIT_W    = 2;

endpackage

// File: rtl/button_debounce.sv
// Active-low push-button conditioner: 2-FF synchronizer, debounce filter and
// one-cycle press pulse on the 1->0 transition of the clean level.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk100_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_reg;
    logic             sync2_reg;
    logic             clean_reg;
    logic             clean_prev_reg;
    logic             press_reg;
    logic [CNT_W-1:0] cnt_reg;

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            sync1_reg      <= 1'b1;
            sync2_reg      <= 1'b1;
            clean_reg      <= 1'b1;
            clean_prev_reg <= 1'b1;
            press_reg      <= 1'b0;
            cnt_reg        <= '0;
        end else begin
            sync1_reg <= btn_i;
            sync2_reg <= sync1_reg;
            // Count only while the synchronized level disagrees; any bounce restarts.
            if (sync2_reg != clean_reg) begin
                if (cnt_reg == CNT_LAST) begin
                    clean_reg <= sync2_reg;
                    cnt_reg   <= '0;
                end else begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end else begin
                cnt_reg <= '0;
            end
            clean_prev_reg <= clean_reg;
            press_reg      <= clean_prev_reg & ~clean_reg;
        end
    end

    assign press_o = press_reg;

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch control: conditions three buttons, runs the IDLE/RUN/EDIT FSM and
// produces the tick prescaler strobe and the edit/clear commands for the datapath.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int CLK_FREQ_HZ     = 100_000_000,
    parameter int TICK_HZ         = 100,
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic               clk100_i,
    input  logic               rst_i,
    input  logic               start_stop_i,
    input  logic               set_i,
    input  logic               change_i,
    output logic               run_o,
    output logic               tick_o,
    output logic               edit_o,
    output logic [DIGIT_W-1:0] edit_digit_o,
    output logic               inc_o,
    output logic               clr_o
);

    localparam int TICK_DIV = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W    = $clog2(TICK_DIV);
    localparam logic [PRE_W-1:0]   PRE_LAST   = PRE_W'(TICK_DIV - 1);
    localparam logic [DIGIT_W-1:0] DIGIT_LAST = DIGIT_W'(NUM_DIGITS - 1);

    // Bit order: 0 = start_stop, 1 = set, 2 = change.
    logic [2:0] raw;
    logic [2:0] press;

    assign raw = {change_i, set_i, start_stop_i};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_btn
            button_debounce #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_debounce (
                .clk100_i(clk100_i),
                .rst_i   (rst_i),
                .btn_i   (raw[gi]),
                .press_o (press[gi])
            );
        end
    endgenerate

    logic press_ss;
    logic press_set;
    logic press_chg;

    assign press_ss  = press[0];
    assign press_set = press[1];
    assign press_chg = press[2];

    state_t             state_reg, state_next;
    logic [DIGIT_W-1:0] digit_reg, digit_next;
    logic [PRE_W-1:0]   pre_reg, pre_next;
    logic               tick_reg, tick_next;
    logic               inc_reg, inc_next;
    logic               clr_reg, clr_next;
    logic               run_reg;
    logic               edit_reg;

    always_ff @(posedge clk100_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= ST_IDLE;
            digit_reg <= '0;
            pre_reg   <= '0;
            tick_reg  <= 1'b0;
            inc_reg   <= 1'b0;
            clr_reg   <= 1'b0;
            run_reg   <= 1'b0;
            edit_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            digit_reg <= digit_next;
            pre_reg   <= pre_next;
            tick_reg  <= tick_next;
            inc_reg   <= inc_next;
            clr_reg   <= clr_next;
            run_reg   <= (state_next == ST_RUN);
            edit_reg  <= (state_next == ST_EDIT);
        end
    end

    // Priority start_stop > set > change; losers in the same cycle are dropped.
    always_comb begin
        state_next = state_reg;
        digit_next = digit_reg;
        case (state_reg)
            ST_IDLE: begin
                if (press_ss) begin
                    state_next = ST_RUN;
                end else if (press_set) begin
                    state_next = ST_EDIT;
                    digit_next = '0;
                end
            end
            ST_RUN: begin
                if (press_ss) begin
                    state_next = ST_IDLE;
                end
            end
            ST_EDIT: begin
                if (press_ss) begin
                    state_next = ST_IDLE;
                    digit_next = '0;
                end else if (press_set) begin
                    if (digit_reg == DIGIT_LAST) begin
                        state_next = ST_IDLE;
                        digit_next = '0;
                    end else begin
                        digit_next = digit_reg + DIGIT_W'(1);
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                digit_next = '0;
            end
        endcase
    end

    // Prescaler only advances while staying in RUN, so every exit leaves it at 0.
    always_comb begin
        inc_next  = (state_reg == ST_EDIT) && !press_ss && !press_set && press_chg;
        clr_next  = (state_reg == ST_IDLE) && !press_ss && !press_set && press_chg;
        pre_next  = '0;
        tick_next = 1'b0;
        if ((state_reg == ST_RUN) && (state_next == ST_RUN)) begin
            pre_next  = (pre_reg == PRE_LAST) ? '0 : pre_reg + PRE_W'(1);
            tick_next = (pre_next == PRE_LAST);
        end
    end

    assign run_o        = run_reg;
    assign tick_o       = tick_reg;
    assign edit_o       = edit_reg;
    assign edit_digit_o = digit_reg;
    assign inc_o        = inc_reg;
    assign clr_o        = clr_reg;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl: expected output events are queued with their
// cycle when a press is driven and compared when the monitor reaches that cycle.
module tb_stopwatch_ctrl;

    localparam int LAT  = 7;   // first low sample -> outputs updated (DEBOUNCE_CYCLES=4)
    localparam int TDIV = 10;
    localparam logic [2:0] SS  = 3'b001;
    localparam logic [2:0] SET = 3'b010;
    localparam logic [2:0] CHG = 3'b100;

    typedef struct {
        int         cyc;
        logic [6:0] vec;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] btn_n;
    logic       run_o, tick_o, edit_o, inc_o, clr_o;
    logic [1:0] edit_digit_o;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    logic mon_en = 1'b0;
    logic [3:0] prev_lvl = 4'h0;
    exp_t sb[$];

    stopwatch_ctrl #(
        .CLK_FREQ_HZ    (1000),
        .TICK_HZ        (100),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk100_i    (clk),
        .rst_i       (rst),
        .start_stop_i(btn_n[0]),
        .set_i       (btn_n[1]),
        .change_i    (btn_n[2]),
        .run_o       (run_o),
        .tick_o      (tick_o),
        .edit_o      (edit_o),
        .edit_digit_o(edit_digit_o),
        .inc_o       (inc_o),
        .clr_o       (clr_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [6:0] mk(input logic r, input logic e, input logic [1:0] d,
                                      input logic t, input logic i, input logic c);
        return {r, e, d, t, i, c};
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic push(input int c, input logic [6:0] v);
        exp_t e;
        e.cyc = c;
        e.vec = v;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: a queued event must appear at its cycle; anything else is unexpected.
    always @(negedge clk) begin
        logic [6:0] v;
        exp_t       e;
        v = {run_o, edit_o, edit_digit_o, tick_o, inc_o, clr_o};
        if (mon_en) begin
            if (sb.size() > 0 && sb[0].cyc == cyc) begin
                e = sb.pop_front();
                chk("event", {1'b0, v}, {1'b0, e.vec});
            end else if (v !== {prev_lvl, 3'b000}) begin
                chk("unexpected", {1'b0, v}, {1'b0, prev_lvl, 3'b000});
            end
        end
        prev_lvl <= v[6:3];
    end

    // Press buttons in mask, hold 8 cycles, release and let it settle.
    task automatic press_expect(input logic [2:0] mask, input logic [6:0] v);
        int n;
        btn_n = ~mask;
        n = cyc + 1;
        push(n + LAT, v);
        step(8);
        btn_n = 3'b111;
        step(10);
    endtask

    // Start with mask, later stop with start_stop; queue run edge, ticks and stop edge.
    task automatic run_session(input logic [2:0] mask, input int hold1, input int gap,
                               input int hold2);
        int n1, r, s;
        btn_n = ~mask;
        n1 = cyc + 1;
        r  = n1 + LAT;
        s  = n1 + hold1 + gap + LAT;
        push(r, mk(1, 0, 2'd0, 0, 0, 0));
        for (int t = r + TDIV - 1; t < s; t += TDIV) push(t, mk(1, 0, 2'd0, 1, 0, 0));
        push(s, mk(0, 0, 2'd0, 0, 0, 0));
        step(hold1);
        btn_n = 3'b111;
        step(gap);
        btn_n = ~SS;
        step(hold2);
        btn_n = 3'b111;
        step(12);
    endtask

    task automatic reset_pulse(input string tag);
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk({tag, "_run"},   {7'd0, run_o},        8'd0);
        chk({tag, "_tick"},  {7'd0, tick_o},       8'd0);
        chk({tag, "_edit"},  {7'd0, edit_o},       8'd0);
        chk({tag, "_digit"}, {6'd0, edit_digit_o}, 8'd0);
        chk({tag, "_inc"},   {7'd0, inc_o},        8'd0);
        chk({tag, "_clr"},   {7'd0, clr_o},        8'd0);
        step(2);
        #2 rst = 1'b0;
        mon_en = 1'b1;
        step(20);
    endtask

    initial begin
        int n;
        rst   = 1'b1;
        btn_n = 3'b111;
        step(3);
        #1;
        chk("reset_run",   {7'd0, run_o},        8'd0);
        chk("reset_tick",  {7'd0, tick_o},       8'd0);
        chk("reset_edit",  {7'd0, edit_o},       8'd0);
        chk("reset_digit", {6'd0, edit_digit_o}, 8'd0);
        chk("reset_inc",   {7'd0, inc_o},        8'd0);
        chk("reset_clr",   {7'd0, clr_o},        8'd0);
        #1 rst = 1'b0;
        mon_en = 1'b1;
        step(5);

        // Start/stop with 20-cycle holds.
        run_session(SS, 20, 12, 20);

        // Bounce: toggling every 2 cycles must not be accepted.
        for (int i = 0; i < 5; i++) begin
            btn_n = ~SS;
            step(2);
            btn_n = 3'b111;
            step(2);
        end
        step(10);
        chk("bounce_run", {7'd0, run_o}, 8'd0);

        // Long hold gives exactly one transition.
        run_session(SS, 50, 12, 20);

        // Edit walk.
        press_expect(SET, mk(0, 1, 2'd0, 0, 0, 0));
        for (int i = 0; i < 3; i++) press_expect(CHG, mk(0, 1, 2'd0, 0, 1, 0));
        press_expect(SET, mk(0, 1, 2'd1, 0, 0, 0));
        press_expect(SET, mk(0, 1, 2'd2, 0, 0, 0));
        press_expect(SET, mk(0, 1, 2'd3, 0, 0, 0));
        press_expect(SET, mk(0, 0, 2'd0, 0, 0, 0));

        // Priority: start_stop beats set in IDLE; change alone clears.
        run_session(SS | SET, 20, 12, 20);
        press_expect(CHG, mk(0, 0, 2'd0, 0, 0, 1));

        // Priority inside EDIT, then abort with start_stop.
        press_expect(SET, mk(0, 1, 2'd0, 0, 0, 0));
        press_expect(SET | CHG, mk(0, 1, 2'd1, 0, 0, 0));
        press_expect(SS | CHG, mk(0, 0, 2'd0, 0, 0, 0));

        // Resume: stop when prescaler sits at 6, then restart for a full period.
        run_session(SS, 20, 17, 20);
        run_session(SS, 20, 12, 20);

        // Asynchronous reset mid-RUN.
        btn_n = ~SS;
        n = cyc + 1;
        push(n + LAT, mk(1, 0, 2'd0, 0, 0, 0));
        step(10);
        btn_n = 3'b111;
        reset_pulse("rst_mid_run");

        // Asynchronous reset mid-EDIT at digit 1.
        press_expect(SET, mk(0, 1, 2'd0, 0, 0, 0));
        press_expect(SET, mk(0, 1, 2'd1, 0, 0, 0));
        reset_pulse("rst_mid_edit");

        step(5);
        chk("queue_drained", 8'(sb.size()), 8'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/stopwatch_ctrl.md
# stopwatch_ctrl

Control unit for the four-digit stopwatch. It conditions the three raw active-low push-buttons (start_stop, set, change), runs the RUN/STOP/EDIT mode state machine, and generates the timing strobes and edit commands that drive the BCD counter/display datapath. It owns no time digits itself. The datapath consumes tick_o, inc_o, clr_o and edit_digit_o.

## Interface
- CLK_FREQ_HZ, 100_000_000, clk100_i frequency.
- TICK_HZ, 100, counting resolution. TICK_DIV = CLK_FREQ_HZ/TICK_HZ must be an integer ≥ 2.
- DEBOUNCE_CYCLES, 1_000_000, consecutive stable cycles required to accept a button level. Must be ≥ 1.
- clk100_i  in  1  system clock, single clock domain.
- rst_i  in  1  asynchronous, active-high reset.
- start_stop_i  in  1  raw button, active-low, asynchronous to clk100_i.
- set_i  in  1  raw button, active-low, asynchronous.
- change_i  in  1  raw button, active-low, asynchronous.
- run_o  out  1  high while in RUN.
- tick_o  out  1  one-cycle strobe, once per TICK_DIV cycles while in RUN.
- edit_o  out  1  high while in EDIT.
- edit_digit_o  out  2  digit selected for editing, 0 = least significant.
- inc_o  out  1  one-cycle strobe: increment the digit at edit_digit_o.
- clr_o  out  1  one-cycle strobe: clear all digits to 0.

## Operation
- **Button conditioning, per button:**
  - 2-FF synchronizer.
  - Debounce counter. The clean level takes the synchronized value after it has differed from the current clean level for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
  - A press is a 1→0 transition of the clean level and produces a one-cycle press pulse.
  - Release produces no event. A held button produces exactly one press.
- **States:** ST_IDLE (stopped), ST_RUN, ST_EDIT.
- **ST_IDLE:**
  - start_stop press → ST_RUN.
  - set press → ST_EDIT with edit_digit = 0.
  - change press → clr_o pulse, stay in ST_IDLE.
- **ST_RUN:**
  - start_stop press → ST_IDLE.
  - set and change presses are ignored.
  - The prescaler counts 0..TICK_DIV-1. tick_o is asserted in the cycle the count equals TICK_DIV-1, then the count wraps to 0.
- **ST_EDIT:**
  - change press → inc_o pulse. Digit wrap-around (9→0 or 5→0) is the datapath's job.
  - set press → edit_digit + 1. A set press at digit 3 → ST_IDLE and edit_digit = 0.
  - start_stop press → ST_IDLE (edit aborted, digits keep their values).
- **Simultaneous presses in one cycle:** priority start_stop > set > change. Lower-priority presses in that cycle are discarded, not queued.
- **Prescaler:** cleared to 0 on every exit from ST_RUN. Resuming therefore gives a full TICK_DIV period before the first tick.

## Timing
- **Reset values:**
  - State ST_IDLE.
  - All outputs 0; edit_digit_o = 0.
  - Prescaler 0, debounce counters 0.
  - Synchronizers and clean levels 1 (released).
- **Reset mid-operation:** all of the above take effect immediately and asynchronously. No strobe may appear in the cycle reset deasserts.
- **Press latency:** raw input first sampled low at edge N (then held stable) → press pulse registered at edge N+2+DEBOUNCE_CYCLES.
- **Output latency:** state, run_o, edit_o, edit_digit_o, inc_o and clr_o are updated at the next edge, N+3+DEBOUNCE_CYCLES.
- **First tick:** entering ST_RUN at edge R → first tick_o high in the cycle after edge R+TICK_DIV-1. Subsequent ticks every TICK_DIV cycles.
- **Stopping in RUN:** tick_o is never asserted in the cycle run_o is low.
- **Strobe width:** inc_o and clr_o are exactly one cycle wide.
- **Registered outputs:** all outputs come straight from flops; no combinational path from inputs.

## Structure
- Package stopwatch_pkg holds:
  - State encoding ST_IDLE=2'd0, ST_RUN=2'd1, ST_EDIT=2'd2.
  - NUM_DIGITS=4 and DIGIT_W=2.
- Sub-module button_debounce (parameter DEBOUNCE_CYCLES; ports clk100_i, rst_i, btn_i, press_o) covers the synchronizer, debounce and press detect. It is instantiated three times.
- The top contains the FSM, the prescaler and the edit-digit counter.

## Test plan
All scenarios use CLK_FREQ_HZ=1000, TICK_HZ=100 (TICK_DIV=10), DEBOUNCE_CYCLES=4.
- **Start/stop:** start_stop low 20 cycles → run_o=1 at 7 cycles after the first low sample. tick_o pulses every 10 cycles. A second press → run_o=0 and no further ticks.
- **Bounce rejection:** start_stop toggling every 2 cycles for 20 cycles, then high → no press, run_o stays 0. Held low 50 cycles → exactly one transition.
- **Edit walk:** set press → edit_o=1, digit 0. Three change presses → three single-cycle inc_o, digit 0. Four more set presses → digits 1, 2, 3, then edit_o=0, digit 0.
- **Priority:** start_stop and set pressed in the same cycle from ST_IDLE → ST_RUN, edit_o stays 0. change in IDLE → single clr_o, run_o=0.
- **Resume period:** stop at prescaler count 6, restart → first tick 10 cycles after run_o rises.
- **Async reset:** rst_i pulsed mid-RUN and mid-EDIT → all outputs 0 immediately, state ST_IDLE, no strobe on release.
